// File: rtl/sid_seq_pkg.sv
// Shared types and register map for the SID register-write sequencer.
// Field widths here fix the bus shape; the WAIT count width is a top-level parameter.
package sid_seq_pkg;

  localparam int VOICE_W = 2;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_WAIT  = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAIT
  } state_t;

  // Per-voice register offsets
  localparam logic [ADDR_W-1:0] FREQ_LO = 3'd0;
  localparam logic [ADDR_W-1:0] FREQ_HI = 3'd1;
  localparam logic [ADDR_W-1:0] PW_LO   = 3'd2;
  localparam logic [ADDR_W-1:0] PW_HI   = 3'd3;
  localparam logic [ADDR_W-1:0] ATK     = 3'd4;
  localparam logic [ADDR_W-1:0] SUS     = 3'd5;
  localparam logic [ADDR_W-1:0] WAV     = 3'd6;

  // Filter/volume bank, addressed through voice slot VOICE_FILT
  localparam logic [VOICE_W-1:0] VOICE_FILT = 2'd3;
  localparam logic [ADDR_W-1:0]  FC_LO      = 3'd0;
  localparam logic [ADDR_W-1:0]  FC_HI      = 3'd1;
  localparam logic [ADDR_W-1:0]  RES_FILT   = 3'd2;
  localparam logic [ADDR_W-1:0]  MODE_VOL   = 3'd3;

endpackage

// File: rtl/sid_seq_fifo.sv
// Synchronous show-ahead FIFO, pop data valid whenever not empty; push/pop same cycle keeps level.
// Caller must not push when full or pop when empty; clear empties it in one cycle.
module sid_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_dat = mem[rd_ptr];
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sid_reg_sequencer.sv
// Replays queued WRITE/WAIT commands onto the SID register bus: 4 cycles per WRITE (IDLE/SETUP/STROBE/HOLD),
// first strobe 3 cycles after push; cmd_ready drops when full or flushing. SID_SEQ_TICK_PRESCALE_EN makes WAIT count TICK_DIV-cycle ticks.
module sid_reg_sequencer
  import sid_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WAIT_W     = 24,
  parameter int TICK_DIV   = 12000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_op,
  input  logic [1:0]                    cmd_voice,
  input  logic [2:0]                    cmd_addr,
  input  logic [7:0]                    cmd_data,
  input  logic [WAIT_W-1:0]             cmd_wait,
  input  logic                          flush,
  output logic [1:0]                    bus_voice,
  output logic [2:0]                    bus_addr,
  output logic [7:0]                    bus_data,
  output logic                          bus_we,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  typedef struct packed {
    op_t                 op;
    logic [VOICE_W-1:0]  voice;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [WAIT_W-1:0]   wait_n;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  cmd_t              push_cmd;
  cmd_t              head;
  logic [CMD_W-1:0]  head_raw;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              tick;

  assign push_cmd = '{op: op_t'(cmd_op), voice: cmd_voice, addr: cmd_addr,
                      data: cmd_data, wait_n: cmd_wait};
  assign head     = cmd_t'(head_raw);

  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  // A flush in IDLE discards the head rather than executing it.
  assign pop       = (state == IDLE) && !empty && !flush;
  assign busy      = (state != IDLE) || !empty;

  sid_seq_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (pop),
    .clear    (flush),
    .pop_dat  (head_raw),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

`ifdef SID_SEQ_TICK_PRESCALE_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Held at 0 outside WAIT so the first tick lands TICK_DIV cycles after entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 presc <= '0;
    else if (state != WAIT)  presc <= '0;
    else if (tick)           presc <= '0;
    else                     presc <= presc + PW'(1);
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_voice <= '0;
      bus_addr  <= '0;
      bus_data  <= '0;
      bus_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (head.op == OP_WRITE) begin
              bus_voice <= head.voice;
              bus_addr  <= head.addr;
              bus_data  <= head.data;
              state     <= SETUP;
            end else if (head.wait_n != '0) begin
              cnt   <= head.wait_n;
              state <= WAIT;
            end
          end
        end
        SETUP: begin
          bus_we <= 1'b1;
          state  <= STROBE;
        end
        STROBE: begin
          bus_we <= 1'b0;
          state  <= HOLD;
        end
        HOLD: state <= IDLE;
        WAIT: begin
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (tick) begin
            cnt <= cnt - WAIT_W'(1);
            if (cnt == WAIT_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_reg_sequencer.sv
// Directed bench for sid_reg_sequencer: write timing, burst/full, wait spacing, flush and reset cases.
module tb_sid_reg_sequencer;

`ifdef SID_SEQ_TICK_PRESCALE_EN
  localparam int TICK_DIV = 10;
  localparam int WAIT_N   = 3;
  localparam int GAP      = 35;
`else
  localparam int TICK_DIV = 12000;
  localparam int WAIT_N   = 100;
  localparam int GAP      = 105;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_voice = '0;
  logic [2:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic [23:0] cmd_wait = '0;
  logic        flush = 1'b0;
  logic [1:0]  bus_voice;
  logic [2:0]  bus_addr;
  logic [7:0]  bus_data;
  logic        bus_we;
  logic        busy;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cyc[$];
  logic [7:0] strobe_dat[$];

  sid_reg_sequencer #(
    .FIFO_DEPTH (8),
    .WAIT_W     (24),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_voice (cmd_voice),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_wait  (cmd_wait),
    .flush     (flush),
    .bus_voice (bus_voice),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_we    (bus_we),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_we) begin
      strobe_cyc.push_back(cyc);
      strobe_dat.push_back(bus_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic op, input logic [1:0] v, input logic [2:0] a,
                      input logic [7:0] d, input logic [23:0] w);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_voice = v;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_wait  = w;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic clear_log();
    strobe_cyc.delete();
    strobe_dat.delete();
  endtask

  task automatic wait_strobes(input string tag, input int n, input int budget);
    int k = 0;
    while (strobe_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, strobe_cyc.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    // Reset state
    step();
    step();
    check("rst_bus_we", bus_we, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_bus_data", bus_data, 0);
    rst = 1'b0;
    step();
    check("rst_cmd_ready", cmd_ready, 1);

    // Single write: strobe 3 cycles after the push edge
    clear_log();
    push(1'b0, 2'd0, 3'd6, 8'h11, 24'd0);
    check("single_level", level, 1);
    check("single_busy", busy, 1);
    step();
    check("single_setup_we", bus_we, 0);
    check("single_setup_addr", bus_addr, 6);
    check("single_setup_data", bus_data, 8'h11);
    step();
    check("single_strobe_we", bus_we, 1);
    check("single_strobe_voice", bus_voice, 0);
    step();
    check("single_hold_we", bus_we, 0);
    check("single_hold_data", bus_data, 8'h11);
    step();
    check("single_idle_busy", busy, 0);
    check("single_idle_level", level, 0);
    check("single_strobe_count", strobe_cyc.size(), 1);

    // Burst behind a WAIT so the FIFO fills
    clear_log();
    push(1'b1, 2'd0, 3'd0, 8'h00, 24'd50);
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 2'(i), 3'(i), 8'(8'hA0 + i), 24'd0);
      if (i == 6) begin
        check("burst_level7", level, 7);
        check("burst_ready7", cmd_ready, 1);
      end
    end
    check("burst_level8", level, 8);
    check("burst_ready8", cmd_ready, 0);
    wait_strobes("burst_strobes", 8, 300);
    check("burst_busy_hold", busy, 1);
    step();
    check("burst_busy_fall", busy, 0);
    for (int i = 0; i < strobe_dat.size(); i++) begin
      check($sformatf("burst_data%0d", i), strobe_dat[i], 8'(8'hA0 + i));
      if (i > 0) check($sformatf("burst_gap%0d", i), strobe_cyc[i] - strobe_cyc[i-1], 4);
    end

    // WAIT spacing
    clear_log();
    push(1'b0, 2'd0, 3'd6, 8'h11, 24'd0);
    push(1'b1, 2'd0, 3'd0, 8'h00, 24'(WAIT_N));
    push(1'b0, 2'd0, 3'd6, 8'h10, 24'd0);
    wait_strobes("wait_strobes", 2, 400);
    if (strobe_cyc.size() == 2) begin
      check("wait_gap", strobe_cyc[1] - strobe_cyc[0], GAP);
      check("wait_data2", strobe_dat[1], 8'h10);
    end
    repeat (4) step();

    // WAIT 0
    clear_log();
    push(1'b0, 2'd1, 3'd4, 8'h21, 24'd0);
    push(1'b1, 2'd0, 3'd0, 8'h00, 24'd0);
    push(1'b0, 2'd1, 3'd5, 8'h22, 24'd0);
    wait_strobes("wait0_strobes", 2, 50);
    if (strobe_cyc.size() == 2) check("wait0_gap", strobe_cyc[1] - strobe_cyc[0], 5);
    repeat (4) step();
    check("wait0_idle", busy, 0);

    // Flush during a long WAIT with queued writes
    clear_log();
    push(1'b1, 2'd0, 3'd0, 8'h00, 24'd1000);
    push(1'b0, 2'd0, 3'd6, 8'h31, 24'd0);
    push(1'b0, 2'd0, 3'd6, 8'h32, 24'd0);
    push(1'b0, 2'd0, 3'd6, 8'h33, 24'd0);
    step();
    step();
    check("flushw_level_pre", level, 3);
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_data  = 8'h3F;
    #1;
    check("flushw_ready", cmd_ready, 0);
    step();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    check("flushw_level", level, 0);
    check("flushw_busy", busy, 0);
    repeat (30) step();
    check("flushw_no_strobe", strobe_cyc.size(), 0);

    // Flush during SETUP: the write still strobes once, the queued one is dropped
    clear_log();
    push(1'b0, 2'd3, 3'd3, 8'h5A, 24'd0);
    push(1'b0, 2'd3, 3'd3, 8'h5B, 24'd0);
    check("flushs_level_pre", level, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flushs_level", level, 0);
    check("flushs_strobe_we", bus_we, 1);
    repeat (8) step();
    check("flushs_count", strobe_cyc.size(), 1);
    if (strobe_dat.size() > 0) check("flushs_data", strobe_dat[0], 8'h5A);

    // Reset during STROBE
    clear_log();
    push(1'b0, 2'd2, 3'd3, 8'h77, 24'd0);
    step();
    step();
    check("rstmid_we_pre", bus_we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_we", bus_we, 0);
    check("rstmid_data", bus_data, 0);
    check("rstmid_addr", bus_addr, 0);
    check("rstmid_voice", bus_voice, 0);
    check("rstmid_busy", busy, 0);
    step();
    rst = 1'b0;
    step();
    push(1'b0, 2'd1, 3'd5, 8'h33, 24'd0);
    step();
    step();
    check("rstmid_new_we", bus_we, 1);
    check("rstmid_new_data", bus_data, 8'h33);
    check("rstmid_new_addr", bus_addr, 5);
    check("rstmid_new_voice", bus_voice, 1);
    step();
    step();
    check("rstmid_new_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
